// File: rtl/q_episode_ctrl.sv
// Tic-tac-toe episode sequencer feeding the Q-learning update core.
// Optional per-outcome counters: define Q_STATS_EN.
module q_episode_ctrl #(
    parameter int         UPDATE_LAT  = 3,
    parameter logic [7:0] REWARD_WIN  = 8'd200,
    parameter logic [7:0] REWARD_DRAW = 8'd100,
    parameter logic [7:0] REWARD_LOSS = 8'd0,
    parameter logic [7:0] REWARD_STEP = 8'd50,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  epsilon,
    input  logic [3:0]  greedy_hint,
    input  logic        opp_valid,
    input  logic [3:0]  opp_move,
    output logic        opp_ready,
    output logic        opp_err,
    output logic [3:0]  action,
    output logic [17:0] state,
    output logic [17:0] next_state,
    output logic [7:0]  reward,
    output logic        upd_done,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner
`ifdef Q_STATS_EN
    ,
    output logic [15:0] win_cnt,
    output logic [15:0] loss_cnt,
    output logic [15:0] draw_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SCAN, S_APPLY, S_OPP_WAIT, S_UPDATE, S_DONE
    } phase_t;

    localparam logic [7:0] LAST = 8'(UPDATE_LAT - 1);

    // Out-of-range cell indices read as occupied so they are never legal.
    function automatic logic [1:0] cell_get(input logic [17:0] b,
                                            input logic [3:0] idx);
        logic [17:0] t;
        if (idx == 4'd0 || idx > 4'd9) return 2'b11;
        t = b >> {idx - 4'd1, 1'b0};
        return t[1:0];
    endfunction

    function automatic logic [17:0] cell_set(input logic [17:0] b,
                                             input logic [3:0] idx,
                                             input logic [1:0] v);
        logic [4:0]  sh;
        logic [17:0] m;
        sh = {idx - 4'd1, 1'b0};
        m  = 18'd3 << sh;
        return (b & ~m) | ({16'd0, v} << sh);
    endfunction

    function automatic logic has_line(input logic [17:0] b,
                                      input logic [1:0] p);
        logic [1:0] c [0:8];
        for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
        return (c[0] == p && c[1] == p && c[2] == p) ||
               (c[3] == p && c[4] == p && c[5] == p) ||
               (c[6] == p && c[7] == p && c[8] == p) ||
               (c[0] == p && c[3] == p && c[6] == p) ||
               (c[1] == p && c[4] == p && c[7] == p) ||
               (c[2] == p && c[5] == p && c[8] == p) ||
               (c[0] == p && c[4] == p && c[8] == p) ||
               (c[2] == p && c[4] == p && c[6] == p);
    endfunction

    function automatic logic is_full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < 9; i++)
            if (b[2*i +: 2] == 2'b00) f = 1'b0;
        return f;
    endfunction

    phase_t      phase_q, phase_d;
    logic [17:0] board_q, board_d;
    logic [7:0]  lfsr_q;
    logic [3:0]  cell_q, cell_d;
    logic [3:0]  scan_left_q, scan_left_d;
    logic [7:0]  upd_cnt_q, upd_cnt_d;
    logic [17:0] s_q, s_d;
    logic [17:0] ns_q, ns_d;
    logic [7:0]  rew_q, rew_d;
    logic [1:0]  win_q, win_d;
    logic        term_q, term_d;

    logic [17:0] agent_board, opp_board;
    logic        opp_legal, explore;
    logic [3:0]  lfsr_lo, rand_cell, hint_next, scan_next;

    assign agent_board = cell_set(board_q, cell_q, 2'b01);
    assign opp_board   = cell_set(board_q, opp_move, 2'b10);
    assign opp_legal   = cell_get(board_q, opp_move) == 2'b00;
    assign explore     = lfsr_q < epsilon;
    assign lfsr_lo     = lfsr_q[3:0];
    assign rand_cell   = (lfsr_lo >= 4'd9 ? lfsr_lo - 4'd9 : lfsr_lo) + 4'd1;
    // A rejected hint resumes the search just past it, wrapping 9 -> 1.
    assign hint_next   = (greedy_hint >= 4'd1 && greedy_hint <= 4'd8) ?
                         greedy_hint + 4'd1 : 4'd1;
    assign scan_next   = (cell_q == 4'd9) ? 4'd1 : cell_q + 4'd1;

    always_comb begin
        phase_d     = phase_q;
        board_d     = board_q;
        cell_d      = cell_q;
        scan_left_d = scan_left_q;
        upd_cnt_d   = upd_cnt_q;
        s_d         = s_q;
        ns_d        = ns_q;
        rew_d       = rew_q;
        win_d       = win_q;
        term_d      = term_q;
        opp_err     = 1'b0;
        upd_done    = 1'b0;
        unique case (phase_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    board_d = '0;
                    win_d   = 2'b00;
                    phase_d = S_SELECT;
                end
            end
            S_SELECT: begin
                scan_left_d = 4'd9;
                if (explore) begin
                    cell_d  = rand_cell;
                    phase_d = S_SCAN;
                end else if (cell_get(board_q, greedy_hint) == 2'b00) begin
                    cell_d  = greedy_hint;
                    phase_d = S_APPLY;
                end else begin
                    cell_d  = hint_next;
                    phase_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cell_get(board_q, cell_q) == 2'b00) begin
                    phase_d = S_APPLY;
                end else if (scan_left_q == 4'd1) begin
                    phase_d = S_DONE;
                end else begin
                    cell_d      = scan_next;
                    scan_left_d = scan_left_q - 4'd1;
                end
            end
            S_APPLY: begin
                s_d     = board_q;
                board_d = agent_board;
                if (has_line(agent_board, 2'b01)) begin
                    rew_d   = REWARD_WIN;
                    win_d   = 2'b01;
                    ns_d    = agent_board;
                    term_d  = 1'b1;
                    phase_d = S_UPDATE;
                end else if (is_full(agent_board)) begin
                    rew_d   = REWARD_DRAW;
                    ns_d    = agent_board;
                    term_d  = 1'b1;
                    phase_d = S_UPDATE;
                end else begin
                    term_d  = 1'b0;
                    phase_d = S_OPP_WAIT;
                end
            end
            S_OPP_WAIT: begin
                if (opp_valid) begin
                    if (!opp_legal) begin
                        opp_err = 1'b1;
                    end else begin
                        board_d = opp_board;
                        ns_d    = opp_board;
                        phase_d = S_UPDATE;
                        if (has_line(opp_board, 2'b10)) begin
                            rew_d  = REWARD_LOSS;
                            win_d  = 2'b10;
                            term_d = 1'b1;
                        end else if (is_full(opp_board)) begin
                            rew_d  = REWARD_DRAW;
                            term_d = 1'b1;
                        end else begin
                            rew_d  = REWARD_STEP;
                            term_d = 1'b0;
                        end
                    end
                end
            end
            S_UPDATE: begin
                if (upd_cnt_q == LAST) begin
                    upd_done  = 1'b1;
                    upd_cnt_d = 8'd0;
                    phase_d   = term_q ? S_DONE : S_SELECT;
                end else begin
                    upd_cnt_d = upd_cnt_q + 8'd1;
                end
            end
            default: phase_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q     <= S_IDLE;
            board_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            cell_q      <= '0;
            scan_left_q <= '0;
            upd_cnt_q   <= '0;
            s_q         <= '0;
            ns_q        <= '0;
            rew_q       <= '0;
            win_q       <= '0;
            term_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            board_q     <= board_d;
            lfsr_q      <= {lfsr_q[6:0],
                            lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            cell_q      <= cell_d;
            scan_left_q <= scan_left_d;
            upd_cnt_q   <= upd_cnt_d;
            s_q         <= s_d;
            ns_q        <= ns_d;
            rew_q       <= rew_d;
            win_q       <= win_d;
            term_q      <= term_d;
        end
    end

`ifdef Q_STATS_EN
    logic done_entry;
    assign done_entry = (phase_d == S_DONE) && (phase_q != S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt  <= '0;
            loss_cnt <= '0;
            draw_cnt <= '0;
        end else if (done_entry) begin
            if (win_q == 2'b01 && win_cnt != 16'hFFFF)
                win_cnt <= win_cnt + 16'd1;
            if (win_q == 2'b10 && loss_cnt != 16'hFFFF)
                loss_cnt <= loss_cnt + 16'd1;
            if (win_q == 2'b00 && draw_cnt != 16'hFFFF)
                draw_cnt <= draw_cnt + 16'd1;
        end
    end
`endif

    assign opp_ready  = phase_q == S_OPP_WAIT;
    assign action     = (phase_q == S_UPDATE) ? cell_q : 4'd0;
    assign state      = s_q;
    assign next_state = ns_q;
    assign reward     = rew_q;
    assign busy       = phase_q != S_IDLE && phase_q != S_DONE;
    assign done       = phase_q == S_DONE;
    assign winner     = win_q;

endmodule
